cfi_log_serializer: RTL and testbench

- Parametrised successor to the single-entry CFI commit-log staging controller.
- Accepts up to NR_COMMIT_PORTS control-flow logs per cycle from commit and buffers whole commit bundles in a STAGE_DEPTH-deep FIFO.
- Drains up to NR_OUT_PORTS logs per cycle, in program order, into the CFI log queue over a valid/ready handshake.
- Halts commit only when the staging FIFO is full; supports flush and flags protocol violations.

---
 rtl/cfi_log_serializer.sv | 131 +++++++++++++
 tb/tb_cfi_log_serializer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cfi_log_serializer.sv
// Stages whole commit bundles of control-flow logs in a small FIFO and drains them,
// lowest port first and never mixing two bundles, into the CFI log queue.
package ariane_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic        is_mispredict;
    } cfi_log_t;
endpackage

module cfi_log_serializer
    import ariane_pkg::*;
#(
    parameter int NR_COMMIT_PORTS = 2,
    parameter int NR_OUT_PORTS    = 1,
    parameter int STAGE_DEPTH     = 2
) (
    input  logic                                               clk_i,
    input  logic                                               rst_i,
    input  cfi_log_t [NR_COMMIT_PORTS-1:0]                     log_i,
    input  logic [NR_COMMIT_PORTS-1:0]                         log_valid_i,
    input  logic                                               flush_i,
    input  logic                                               queue_ready_i,
    output logic [NR_OUT_PORTS-1:0]                            queue_valid_o,
    output cfi_log_t [NR_OUT_PORTS-1:0]                        queue_data_o,
    output logic                                               cfi_halt_o,
    output logic [$clog2(STAGE_DEPTH*NR_COMMIT_PORTS+1)-1:0]   pending_o,
    output logic                                               overflow_o
);
    localparam int PEND_W = $clog2(STAGE_DEPTH*NR_COMMIT_PORTS+1);
    localparam int CW     = $clog2(STAGE_DEPTH+1);
    localparam int PW     = (STAGE_DEPTH > 1) ? $clog2(STAGE_DEPTH) : 1;

    cfi_log_t [NR_COMMIT_PORTS-1:0] data_q [STAGE_DEPTH];
    logic [NR_COMMIT_PORTS-1:0]     mask_q [STAGE_DEPTH];
    logic [PW-1:0]                  rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]                  count_q;
    logic [PEND_W-1:0]              pending_q;
    logic                           overflow_q;

    logic [NR_COMMIT_PORTS-1:0]     head_mask, taken, remain;
    cfi_log_t [NR_COMMIT_PORTS-1:0] head_data;
    int                             rank [NR_COMMIT_PORTS];
    logic                           drain, pop, push;
    logic [PEND_W-1:0]              pend_next;

    function automatic logic [PEND_W-1:0] popcnt(input logic [NR_COMMIT_PORTS-1:0] m);
        logic [PEND_W-1:0] s;
        s = '0;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) s = s + PEND_W'(m[i]);
        return s;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(STAGE_DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    assign cfi_halt_o = (count_q == CW'(STAGE_DEPTH));
    assign pending_o  = pending_q;
    assign overflow_o = overflow_q;

    // Lane j carries the head's j-th remaining valid log (rank = set bits below it).
    always_comb begin
        int r;
        head_mask     = (count_q != '0) ? mask_q[rd_ptr_q] : '0;
        head_data     = data_q[rd_ptr_q];
        queue_valid_o = '0;
        queue_data_o  = '0;
        taken         = '0;
        r             = 0;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            rank[i] = r;
            if (head_mask[i]) r = r + 1;
        end
        for (int j = 0; j < NR_OUT_PORTS; j++) begin
            for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
                if (head_mask[i] && rank[i] == j) begin
                    queue_valid_o[j] = 1'b1;
                    queue_data_o[j]  = head_data[i];
                    taken[i]         = 1'b1;
                end
            end
        end
    end

    // Push uses the pre-pop count, so a slot freed this cycle is not reused until the next.
    always_comb begin
        drain     = queue_valid_o[0] & queue_ready_i;
        remain    = head_mask & ~taken;
        pop       = drain && (remain == '0);
        push      = (|log_valid_i) && !cfi_halt_o;
        pend_next = pending_q;
        if (drain) pend_next = pend_next - popcnt(taken);
        if (push)  pend_next = pend_next + popcnt(log_valid_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i && push) data_q[wr_ptr_q] <= log_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            for (int d = 0; d < STAGE_DEPTH; d++) mask_q[d] <= '0;
        end else if (flush_i) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            pending_q <= '0;
            for (int d = 0; d < STAGE_DEPTH; d++) mask_q[d] <= '0;
        end else begin
            if ((|log_valid_i) && cfi_halt_o) overflow_q <= 1'b1;
            // wr and rd only coincide when empty (no drain) or full (no push).
            if (push) begin
                mask_q[wr_ptr_q] <= log_valid_i;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (drain) mask_q[rd_ptr_q] <= remain;
            if (pop)   rd_ptr_q <= ptr_inc(rd_ptr_q);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            pending_q <= pend_next;
        end
    end
endmodule

// File: tb/tb_cfi_log_serializer.sv
// Bench for cfi_log_serializer: three parameterisations, directed bundles, expected-log
// queues filled by the drivers and drained by a handshake monitor.
module tb_cfi_log_serializer;
    import ariane_pkg::*;
    localparam int LW = $bits(cfi_log_t);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // u0: defaults (2 ports, 1 lane, depth 2)
    cfi_log_t [1:0] log0;
    logic [1:0]     lv0;
    logic           flush0, rdy0;
    logic [0:0]     qv0;
    cfi_log_t [0:0] qd0;
    logic           halt0, ovf0;
    logic [2:0]     pend0;
    // u1: 4 ports, 2 lanes, depth 2
    cfi_log_t [3:0] log1;
    logic [3:0]     lv1;
    logic           flush1, rdy1;
    logic [1:0]     qv1;
    cfi_log_t [1:0] qd1;
    logic           halt1, ovf1;
    logic [3:0]     pend1;
    // u2: 2 ports, 1 lane, depth 3
    cfi_log_t [1:0] log2;
    logic [1:0]     lv2;
    logic           flush2, rdy2;
    logic [0:0]     qv2;
    cfi_log_t [0:0] qd2;
    logic           halt2, ovf2;
    logic [2:0]     pend2;

    logic [LW-1:0] exp0[$];
    logic [LW-1:0] exp1[$];
    logic [LW-1:0] exp2[$];

    cfi_log_serializer #(.NR_COMMIT_PORTS(2), .NR_OUT_PORTS(1), .STAGE_DEPTH(2)) u0 (
        .clk_i(clk), .rst_i(rst), .log_i(log0), .log_valid_i(lv0), .flush_i(flush0),
        .queue_ready_i(rdy0), .queue_valid_o(qv0), .queue_data_o(qd0),
        .cfi_halt_o(halt0), .pending_o(pend0), .overflow_o(ovf0));
    cfi_log_serializer #(.NR_COMMIT_PORTS(4), .NR_OUT_PORTS(2), .STAGE_DEPTH(2)) u1 (
        .clk_i(clk), .rst_i(rst), .log_i(log1), .log_valid_i(lv1), .flush_i(flush1),
        .queue_ready_i(rdy1), .queue_valid_o(qv1), .queue_data_o(qd1),
        .cfi_halt_o(halt1), .pending_o(pend1), .overflow_o(ovf1));
    cfi_log_serializer #(.NR_COMMIT_PORTS(2), .NR_OUT_PORTS(1), .STAGE_DEPTH(3)) u2 (
        .clk_i(clk), .rst_i(rst), .log_i(log2), .log_valid_i(lv2), .flush_i(flush2),
        .queue_ready_i(rdy2), .queue_valid_o(qv2), .queue_data_o(qd2),
        .cfi_halt_o(halt2), .pending_o(pend2), .overflow_o(ovf2));

    function automatic cfi_log_t mk(input logic [31:0] pc);
        cfi_log_t l;
        l.pc            = pc;
        l.is_mispredict = pc[2];
        return l;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted lane must match the head of its expected queue.
    always @(negedge clk) begin
        if (qv0[0] === 1'b1 && rdy0 === 1'b1) begin
            if (exp0.size() == 0) chk("u0_unexpected_log", 64'(qd0[0]), 64'(0) - 1);
            else chk("u0_lane0_data", 64'(qd0[0]), 64'(exp0.pop_front()));
        end
        if (qv1[0] === 1'b1 && rdy1 === 1'b1) begin
            chk("u1_lanes_contiguous", 64'(qv1 == 2'b10), 64'(0));
            for (int j = 0; j < 2; j++) begin
                if (qv1[j]) begin
                    if (exp1.size() == 0) chk("u1_unexpected_log", 64'(qd1[j]), 64'(0) - 1);
                    else chk("u1_lane_data", 64'(qd1[j]), 64'(exp1.pop_front()));
                end
            end
        end
        if (qv2[0] === 1'b1 && rdy2 === 1'b1) begin
            if (exp2.size() == 0) chk("u2_unexpected_log", 64'(qd2[0]), 64'(0) - 1);
            else chk("u2_lane0_data", 64'(qd2[0]), 64'(exp2.pop_front()));
        end
    end

    task automatic offer0(input logic [1:0] m, input logic [31:0] pc_a, input logic [31:0] pc_b,
                          input bit expect_store);
        log0[0] = mk(pc_a);
        log0[1] = mk(pc_b);
        lv0     = m;
        if (expect_store) begin
            if (m[0]) exp0.push_back(mk(pc_a));
            if (m[1]) exp0.push_back(mk(pc_b));
        end
    endtask

    logic [1:0] mask_tab [10];
    int guard;

    initial begin
        log0 = '0; lv0 = '0; flush0 = 1'b0; rdy0 = 1'b0;
        log1 = '0; lv1 = '0; flush1 = 1'b0; rdy1 = 1'b0;
        log2 = '0; lv2 = '0; flush2 = 1'b0; rdy2 = 1'b0;
        mask_tab = '{2'b01, 2'b11, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11, 2'b11, 2'b01, 2'b10};
        rst = 1'b1;
        step(); step();
        rst = 1'b0;

        chk("reset_valid", 64'(qv0), 64'(0));
        chk("reset_halt", 64'(halt0), 64'(0));
        chk("reset_pending", 64'(pend0), 64'(0));
        chk("reset_overflow", 64'(ovf0), 64'(0));
        chk("reset_u1_valid", 64'(qv1), 64'(0));

        // Single bundle {A,B}, always ready.
        rdy0 = 1'b1;
        offer0(2'b11, 32'h100, 32'h104, 1'b1);
        step(); lv0 = '0;
        chk("t1_c1_valid", 64'(qv0), 64'(1));
        chk("t1_c1_halt", 64'(halt0), 64'(0));
        chk("t1_c1_pending", 64'(pend0), 64'(2));
        step();
        chk("t1_c2_valid", 64'(qv0), 64'(1));
        chk("t1_c2_pending", 64'(pend0), 64'(1));
        step();
        chk("t1_c3_valid", 64'(qv0), 64'(0));
        chk("t1_c3_pending", 64'(pend0), 64'(0));

        // Fill to halt, third offer is a protocol violation and is dropped.
        rdy0 = 1'b0;
        offer0(2'b11, 32'h200, 32'h204, 1'b1); step();
        chk("t2_halt_after_one", 64'(halt0), 64'(0));
        offer0(2'b11, 32'h210, 32'h214, 1'b1); step();
        chk("t2_halt_full", 64'(halt0), 64'(1));
        chk("t2_pending_full", 64'(pend0), 64'(4));
        chk("t2_overflow_before", 64'(ovf0), 64'(0));
        offer0(2'b11, 32'h2f0, 32'h2f4, 1'b0); step(); lv0 = '0;
        chk("t2_overflow_set", 64'(ovf0), 64'(1));
        chk("t2_pending_kept", 64'(pend0), 64'(4));
        rdy0 = 1'b1;
        step();
        chk("t2_halt_mid_bundle", 64'(halt0), 64'(1));
        chk("t2_pending_3", 64'(pend0), 64'(3));
        step();
        chk("t2_halt_after_pop", 64'(halt0), 64'(0));
        chk("t2_pending_2", 64'(pend0), 64'(2));
        step(); step();
        chk("t2_drained_valid", 64'(qv0), 64'(0));
        chk("t2_overflow_sticky", 64'(ovf0), 64'(1));

        // Ready toggling: data must hold while stalled.
        rdy0 = 1'b0;
        offer0(2'b11, 32'h300, 32'h304, 1'b1); step(); lv0 = '0;
        chk("t4_first_data", 64'(qd0[0]), 64'(mk(32'h300)));
        rdy0 = 1'b1; step();
        rdy0 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("t4_hold_valid", 64'(qv0), 64'(1));
            chk("t4_hold_data", 64'(qd0[0]), 64'(mk(32'h304)));
            step();
        end
        rdy0 = 1'b1; step();
        chk("t4_done_valid", 64'(qv0), 64'(0));

        // Flush with a simultaneous offer while full; overflow was cleared by reset.
        rst = 1'b1; step(); rst = 1'b0;
        chk("t5_reset_overflow", 64'(ovf0), 64'(0));
        rdy0 = 1'b0;
        offer0(2'b11, 32'h400, 32'h404, 1'b0); step();
        offer0(2'b11, 32'h410, 32'h414, 1'b0); step();
        chk("t5_halt_before_flush", 64'(halt0), 64'(1));
        flush0 = 1'b1;
        offer0(2'b01, 32'h4f0, 32'h4f4, 1'b0); step();
        flush0 = 1'b0; lv0 = '0;
        chk("t5_pending", 64'(pend0), 64'(0));
        chk("t5_valid", 64'(qv0), 64'(0));
        chk("t5_halt", 64'(halt0), 64'(0));
        chk("t5_overflow", 64'(ovf0), 64'(0));
        rdy0 = 1'b1;
        offer0(2'b10, 32'h500, 32'h504, 1'b1); step(); lv0 = '0;
        chk("t5_after_flush_pending", 64'(pend0), 64'(1));
        step();
        chk("t5_after_flush_empty", 64'(qv0), 64'(0));

        // Wide instance: masks 1011 then 0110, two lanes.
        rdy1 = 1'b1;
        for (int i = 0; i < 4; i++) log1[i] = mk(32'h600 + 32'(i * 4));
        lv1 = 4'b1011;
        exp1.push_back(mk(32'h600)); exp1.push_back(mk(32'h604)); exp1.push_back(mk(32'h60c));
        step(); lv1 = '0;
        chk("t3_c1_lanes", 64'(qv1), 64'(2'b11));
        chk("t3_c1_pending", 64'(pend1), 64'(3));
        step();
        chk("t3_c2_lanes", 64'(qv1), 64'(2'b01));
        chk("t3_c2_pending", 64'(pend1), 64'(1));
        for (int i = 0; i < 4; i++) log1[i] = mk(32'h700 + 32'(i * 4));
        lv1 = 4'b0110;
        exp1.push_back(mk(32'h704)); exp1.push_back(mk(32'h708));
        step(); lv1 = '0;
        chk("t3_c3_lanes", 64'(qv1), 64'(2'b11));
        step();
        chk("t3_c4_lanes", 64'(qv1), 64'(2'b00));
        chk("t3_c4_pending", 64'(pend1), 64'(0));

        // Depth-3 instance: ten bundles, always ready, commit waits on halt.
        rdy2 = 1'b1;
        for (int b = 0; b < 10; b++) begin
            guard = 0;
            while (halt2 && guard < 50) begin
                lv2 = '0; step(); guard++;
            end
            if (guard >= 50) chk("t6_halt_timeout", 64'(halt2), 64'(0));
            log2[0] = mk(32'h800 + 32'(b * 16));
            log2[1] = mk(32'h804 + 32'(b * 16));
            lv2 = mask_tab[b];
            if (mask_tab[b][0]) exp2.push_back(mk(32'h800 + 32'(b * 16)));
            if (mask_tab[b][1]) exp2.push_back(mk(32'h804 + 32'(b * 16)));
            step();
        end
        lv2 = '0;
        guard = 0;
        while (pend2 != 0 && guard < 100) begin step(); guard++; end
        chk("t6_drain_done", 64'(pend2), 64'(0));
        step();
        chk("t6_valid_idle", 64'(qv2), 64'(0));
        chk("t6_overflow", 64'(ovf2), 64'(0));

        chk("u0_queue_empty", 64'(exp0.size()), 64'(0));
        chk("u1_queue_empty", 64'(exp1.size()), 64'(0));
        chk("u2_queue_empty", 64'(exp2.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
